// File: rtl/sub2_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sub_bit.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out.
module sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub2_serial.sv
// Bit-serial subtractor: latches a/b, resolves one bit per clock LSB first,
// then presents diff/borrow/overflow until the consumer takes them.
module sub2_serial
  import sub2_pkg::*;
#(
  parameter int clock_freq_hz   = 50_000_000,
  parameter int clock_ns_per_hz = 20,
  parameter int WIDTH           = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32 || clock_freq_hz <= 0 || clock_ns_per_hz <= 0) begin : g_bad_cfg
    $error("sub2_serial: illegal parameter setting");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             bit_d, bit_bout;

  sub_bit u_bit (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    br_d       = br_q;
    res_d      = res_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    a_d        = a_q;
    b_d        = b_q;
    case (state_q)
      IDLE: begin
        // Operands are only sampled on an accepted handshake, so idle X's stay out.
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          br_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = {bit_d, res_q[WIDTH-1:1]};
        br_d  = bit_bout;
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          borrow_d   = bit_bout;
          // Signs differ and the result sign departs from the minuend's.
          overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (bit_d != a_q[WIDTH-1]);
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      br_q       <= 1'b0;
      res_q      <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      br_q       <= br_d;
      res_q      <= res_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = res_q;
  assign borrow    = borrow_q;
  assign overflow  = overflow_q;

endmodule
